// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: CPU store-to-IO bus as seen by the UART transmitter.
//   st_we_io   [3:0]  byte write enables; nonzero means a store is valid this cycle
//   st_adr_io  [9:0]  IO word address (byte address bits [11:2])
//   st_data_io [31:0] lane-aligned store data
// master: the CPU store path (drives); slave: the IO responder (samples).
interface io_uart_tx_if;
  logic [3:0]  st_we_io;
  logic [9:0]  st_adr_io;
  logic [31:0] st_data_io;

  modport master (output st_we_io, output st_adr_io, output st_data_io);
  modport slave  (input  st_we_io, input  st_adr_io, input  st_data_io);
endinterface

// File: rtl/io_uart_tx.sv
// io_uart_tx: IO-mapped 8N1 UART transmitter with a small TX FIFO.
//   clk            system clock
//   rst_n          synchronous active-low reset
//   io             store bus (slave): TX data/overflow-clear at TX_ADR, divisor at DIV_ADR
//   uart_tx        serial output, idle high
//   tx_fifo_full   FIFO holds 2**FIFO_AW entries (registered)
//   tx_fifo_empty  FIFO holds no entries (registered)
//   tx_busy        a frame is in progress
//   tx_overflow    sticky: a push was dropped because the FIFO was full
module io_uart_tx #(
  parameter logic [9:0]  TX_ADR    = 10'h000,
  parameter logic [9:0]  DIV_ADR   = 10'h001,
  parameter int unsigned FIFO_AW   = 3,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic            clk,
  input  logic            rst_n,
  io_uart_tx_if.slave     io,
  output logic            uart_tx,
  output logic            tx_fifo_full,
  output logic            tx_fifo_empty,
  output logic            tx_busy,
  output logic            tx_overflow
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     cnt_q, cnt_d;
  logic                 full_q, empty_q;
  logic                 ovf_q, ovf_d;
  logic [15:0]          div_q, div_d;
  logic [15:0]          eff_div;
  logic [15:0]          baud_q, baud_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 bit_end, pop;
  logic                 tx_sel, div_sel, push_req, push_ok, clr_req;

  // A stored divisor of 0 behaves as 1 so every bit lasts at least one cycle.
  assign eff_div = (div_q == '0) ? 16'd1 : div_q;
  assign bit_end = (baud_q == '0);

  assign tx_sel   = (io.st_adr_io == TX_ADR);
  assign div_sel  = (io.st_adr_io == DIV_ADR);
  assign push_req = io.st_we_io[0] && tx_sel;
  // A push into a full FIFO still fits when the head is popped on the same edge.
  assign push_ok  = push_req && (!full_q || pop);
  assign clr_req  = io.st_we_io[1] && tx_sel && io.st_data_io[8];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty_q) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && bit_cnt_q == 3'd7) state_d = STOP;
      STOP:    if (bit_end) state_d = empty_q ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop request and next values of the serialiser datapath.
  // The baud counter is reloaded from the current divisor at every bit start,
  // so a divisor write only affects bits that begin after it.
  always_comb begin
    pop       = 1'b0;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = eff_div - 16'd1;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          baud_d    = eff_div - 16'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          baud_d  = eff_div - 16'd1;
          if (bit_cnt_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty_q) begin
            // Next frame starts straight after the stop bit, no idle gap.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            baud_d  = eff_div - 16'd1;
          end else begin
            tx_d = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO occupancy, sticky overflow and divisor register next values
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    ovf_d = ovf_q;
    if (push_req && !push_ok) ovf_d = 1'b1;
    else if (clr_req)         ovf_d = 1'b0;

    div_d = div_q;
    if (div_sel && io.st_we_io[0]) div_d[7:0]  = io.st_data_io[7:0];
    if (div_sel && io.st_we_io[1]) div_d[15:8] = io.st_data_io[15:8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      div_q     <= DIV_RESET;
      baud_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q     <= cnt_d;
      full_q    <= (cnt_d == CNT_FULL);
      empty_q   <= (cnt_d == '0);
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      baud_q    <= baud_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q] <= io.st_data_io[7:0];
  end

  assign uart_tx       = tx_q;
  assign tx_fifo_full  = full_q;
  assign tx_fifo_empty = empty_q;
  assign tx_busy       = (state_q != IDLE);
  assign tx_overflow   = ovf_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed and randomized checks of io_uart_tx against a
// frame-level reference model (byte queue + bit schedule).
module tb_io_uart_tx;

  logic clk = 1'b0;
  logic rst_n;
  logic uart_tx, full, empty, busy, ovf;

  io_uart_tx_if bus();

  io_uart_tx #(
    .TX_ADR   (10'h000),
    .DIV_ADR  (10'h001),
    .FIFO_AW  (3),
    .DIV_RESET(16'd434)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io           (bus),
    .uart_tx      (uart_tx),
    .tx_fifo_full (full),
    .tx_fifo_empty(empty),
    .tx_busy      (busy),
    .tx_overflow  (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queued bytes, divisor, and the frame on the line
  logic [7:0]  byte_q [$];
  logic [15:0] m_div;
  logic        m_ovf;
  logic        m_busy;
  logic [9:0]  m_frame;   // [0]=start, [8:1]=data LSB first, [9]=stop
  int          m_idx;
  int          m_rem;     // cycles left in the current bit

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int eff();
    return (m_div == 16'd0) ? 1 : int'(m_div);
  endfunction

  task automatic start_frame(input int e);
    logic [7:0] b;
    b       = byte_q.pop_front();
    m_frame = {1'b1, b, 1'b0};
    m_idx   = 0;
    m_rem   = e;
    m_busy  = 1'b1;
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] we,
                            input logic [9:0] adr, input logic [31:0] d);
    int e;
    bit set;
    if (!rst) begin
      byte_q.delete();
      m_div  = 16'd434;
      m_ovf  = 1'b0;
      m_busy = 1'b0;
      m_idx  = 0;
      m_rem  = 0;
      return;
    end
    e = eff();
    if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_idx++;
        if (m_idx == 10) begin
          m_busy = 1'b0;
          if (byte_q.size() > 0) start_frame(e);
        end else begin
          m_rem = e;
        end
      end
    end else if (byte_q.size() > 0) begin
      start_frame(e);
    end
    set = 1'b0;
    if (we[0] && adr == 10'h000) begin
      if (byte_q.size() < 8) byte_q.push_back(d[7:0]);
      else set = 1'b1;
    end
    if (set) m_ovf = 1'b1;
    else if (we[1] && adr == 10'h000 && d[8]) m_ovf = 1'b0;
    if (adr == 10'h001) begin
      if (we[0]) m_div[7:0]  = d[7:0];
      if (we[1]) m_div[15:8] = d[15:8];
    end
  endtask

  task automatic check_all();
    check("uart_tx",  {31'h0, uart_tx}, {31'h0, m_busy ? m_frame[m_idx] : 1'b1});
    check("full",     {31'h0, full},    {31'h0, byte_q.size() == 8});
    check("empty",    {31'h0, empty},   {31'h0, byte_q.size() == 0});
    check("busy",     {31'h0, busy},    {31'h0, m_busy});
    check("overflow", {31'h0, ovf},     {31'h0, m_ovf});
  endtask

  task automatic step(input logic rst, input logic [3:0] we,
                      input logic [9:0] adr, input logic [31:0] d);
    rst_n          = rst;
    bus.st_we_io   = we;
    bus.st_adr_io  = adr;
    bus.st_data_io = d;
    @(posedge clk);
    model_edge(rst, we, adr, d);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'h0, 10'h000, 32'h0);
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b1, 4'b0001, 10'h000, {24'h0, b});
  endtask

  task automatic div_wr(input logic [15:0] v);
    step(1'b1, 4'b0011, 10'h001, {16'h0, v});
  endtask

  logic       line [45];
  logic [9:0] pat;
  int         bc;
  int         r;

  initial begin
    rst_n          = 1'b0;
    bus.st_we_io   = 4'h0;
    bus.st_adr_io  = 10'h0;
    bus.st_data_io = 32'h0;

    // Reset held for three clocks
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 10'h000, 32'h0);
    check("rst_tx",    {31'h0, uart_tx}, 32'h1);
    check("rst_empty", {31'h0, empty},   32'h1);
    check("rst_full",  {31'h0, full},    32'h0);
    check("rst_busy",  {31'h0, busy},    32'h0);
    check("rst_ovf",   {31'h0, ovf},     32'h0);

    // One frame at the reset divisor (434 clks per bit)
    push(8'h3C);
    idle(4345);
    check("div434_done", {31'h0, busy}, 32'h0);

    // div=4, single byte A5: line 0,1,0,1,0,0,1,0,1,1 with 4 clks per bit
    div_wr(16'd4);
    push(8'hA5);
    bc = 0;
    for (int i = 0; i < 45; i++) begin
      idle(1);
      line[i] = uart_tx;
      if (busy) bc++;
    end
    pat = 10'b1101001010;
    check("a5_latency", {31'h0, line[0]}, 32'h0);
    for (int k = 0; k < 10; k++)
      check($sformatf("a5_bit%0d", k), {31'h0, line[4*k+2]}, {31'h0, pat[k]});
    check("a5_busy_clks", 32'(bc), 32'd40);

    // Back-to-back frames: 80 busy clocks with no gap
    push(8'h55);
    push(8'h0F);
    bc = busy ? 1 : 0;
    for (int i = 0; i < 85; i++) begin
      idle(1);
      if (busy) bc++;
    end
    check("b2b_busy_clks", 32'(bc), 32'd80);

    // Fill and overflow: 00 popped at once, 01..08 queued, 09 dropped
    for (int i = 0; i < 10; i++) push(8'(i));
    check("ovf_full", {31'h0, full}, 32'h1);
    check("ovf_set",  {31'h0, ovf},  32'h1);
    idle(400);
    step(1'b1, 4'b0010, 10'h000, 32'h0000_0100);
    check("ovf_clear", {31'h0, ovf}, 32'h0);

    // Lane and address filtering: nothing queued, divisor untouched
    step(1'b1, 4'b0010, 10'h000, 32'h0000_00AA);
    step(1'b1, 4'b1111, 10'h002, 32'hFFFF_FFFF);
    check("filter_empty", {31'h0, empty}, 32'h1);
    check("filter_busy",  {31'h0, busy},  32'h0);
    push(8'h81);
    idle(45);

    // Divisor change during the start bit of a div=4 frame
    push(8'hC3);
    idle(2);
    step(1'b1, 4'b0001, 10'h001, 32'h0000_0008);
    idle(90);

    // Reset in the middle of DATA with bytes still queued
    push(8'h11);
    push(8'h22);
    push(8'h33);
    idle(30);
    rst_n = 1'b0;
    #2;
    check("no_async_busy", {31'h0, busy},    {31'h0, m_busy});
    check("no_async_tx",   {31'h0, uart_tx}, {31'h0, m_busy ? m_frame[m_idx] : 1'b1});
    step(1'b0, 4'h0, 10'h000, 32'h0);
    check("midrst_tx",    {31'h0, uart_tx}, 32'h1);
    check("midrst_empty", {31'h0, empty},   32'h1);
    push(8'h5A);
    idle(4345);

    // Randomized traffic
    div_wr(16'd3);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30)
        step(1'b1, 4'($urandom_range(0, 15)) | 4'b0001, 10'h000, $urandom());
      else if (r < 35)
        step(1'b1, 4'b0010, 10'h000, {23'h0, 1'($urandom_range(0, 1)), 8'h0});
      else if (r < 38)
        div_wr(16'($urandom_range(0, 5)));
      else if (r < 40)
        step(1'b1, 4'($urandom_range(0, 15)), 10'($urandom_range(2, 1023)), $urandom());
      else if (r < 41) begin
        step(1'b0, 4'h0, 10'h000, 32'h0);
        div_wr(16'($urandom_range(0, 5)));
      end else
        idle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
